mem_port_ctrl: RTL
==================

MEM_PORT_CTRL -- requirements
Module: mem_port_ctrl

Interface
REQ-001 Parameters: none; geometry is fixed at 8192 x 32-bit words, 15-bit byte address.
REQ-002 The block SHALL use one clock, clk; reset is synchronous and active-low, reset_b.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 reset_b  in  1  synchronous active-low reset.
REQ-005 req_valid  in  1  request present.
REQ-006 req_ready  out  1  block can accept a request this cycle.
REQ-007 req_rnw  in  1  1=read, 0=write.
REQ-008 req_addr  in  15  byte address; [14:2] word, [1:0] byte lane.
REQ-009 req_size  in  2  00 byte, 01 halfword, 10 word, 11 reserved.
REQ-010 req_signed  in  1  reads: 1 sign-extend, 0 zero-extend.
REQ-011 req_wdata  in  32  write data, right-justified.
REQ-012 rsp_valid  out  1  single-cycle response pulse; no backpressure.
REQ-013 rsp_rdata  out  32  extended read data; 0 for writes and errors.
REQ-014 rsp_err  out  1  request rejected; no RAM write performed.
REQ-015 ram_address  out  13  RAM word address.
REQ-016 ram_din  out  32  RAM write data, lane-aligned.
REQ-017 ram_rnw  out  1  RAM 1=read, 0=write.
REQ-018 ram_cs_b  out  4  active-low byte-lane selects; bit n = bits [8n+7:8n].
REQ-019 ram_dout  in  32  RAM read data, valid one clk after the read issue cycle.

Function
REQ-020 States SHALL be IDLE, ISSUE, ISSUE2, WAIT, RESP; req_ready=1 only in IDLE.
REQ-021 Accept on req_valid&req_ready at edge N; request fields SHALL be registered and not resampled.
REQ-022 Aligned access: ISSUE at N+1 drives ram_* for exactly one cycle; all ram_* outputs SHALL be registered.
REQ-023 Aligned write: ISSUE->RESP; rsp_valid=1 at N+2.
REQ-024 Aligned read: ISSUE->WAIT (capture ram_dout)->RESP; rsp_valid=1 at N+3.
REQ-025 RESP->IDLE; outside RESP, rsp_valid=0 and rsp_rdata/rsp_err hold their last values.
REQ-026 Lanes: byte selects lane addr[1:0]; halfword selects lanes addr[1:0], addr[1:0]+1; word selects all 4.
REQ-027 Write data SHALL be shifted left by 8*addr[1:0]; unselected lanes of ram_din = 0.
REQ-028 Read data SHALL be shifted right by 8*addr[1:0], then truncated to size and extended per req_signed.
REQ-029 Outside ISSUE/ISSUE2: ram_cs_b=4'hF, ram_rnw=1; ram_address/ram_din hold.
REQ-030 Alignment: halfword needs addr[0]=0, word needs addr[1:0]=0; byte is always aligned.
REQ-031 req_size=11 SHALL always give rsp_err=1, rsp_rdata=0, rsp_valid at N+2, ram_cs_b=4'hF throughout.

Reset
REQ-032 While reset_b=0 at an edge: state=IDLE, req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, ram_cs_b=4'hF, ram_rnw=1, ram_address=0, ram_din=0.
REQ-033 req_ready SHALL be 1 in the first cycle after reset_b returns high.
REQ-034 Reset mid-operation SHALL abandon the request with no response; an ISSUE2 half already scheduled SHALL NOT be driven.

Configuration
REQ-035 Macro MISALIGN_SPLIT_EN; undefined: misaligned halfword/word gives rsp_err=1, rsp_rdata=0, rsp_valid at N+2, no RAM access.
REQ-036 Defined: misaligned access SHALL split into two RAM cycles, ISSUE (word w, upper lanes) then ISSUE2 (word w+1 mod 8192, remaining lanes).
REQ-037 Split write: rsp_valid at N+3; split read: low part captured at N+2, high part at N+3 (WAIT), rsp_valid at N+4.
REQ-038 Word 8191 + 1 SHALL wrap to word 0; a halfword at addr[1:0]=1 or 2 is aligned to one word and SHALL NOT split.

Verification
REQ-039 Write word 0x0004 data 0xDEADBEEF -> N+1: address=1, cs_b=0000, rnw=0; rsp_valid N+2, err=0.
REQ-040 Write byte 0x0006 data 0x000000A5 -> cs_b=1011, din=0x00A50000; signed byte read 0x0006 -> rsp_rdata=0xFFFFFFA5 at N+3.
REQ-041 Halfword read 0x0003: macro off -> err=1, rdata=0, no cs_b activity; macro on, RAM 0x0000=0x11223344, 0x0004=0x55667788 -> rdata=0x00008811 at N+4.
REQ-042 MISALIGN_SPLIT_EN, word write 0x7FFE data 0xCAFEF00D -> address 8191 cs_b=0011, then address 0 cs_b=1100; read back 0xCAFEF00D.
REQ-043 req_size=11 and back-to-back req_valid -> err=1 at N+2, req_ready low N+1..N+2, second request accepted at N+3.
REQ-044 reset_b=0 during WAIT of a read -> no rsp_valid, cs_b=1111 next edge, req_ready=1 first cycle after reset release.

Source files
------------

// File: rtl/mem_port_ctrl.sv
// mem_port_ctrl: request/response front end for an 8192x32 byte-lane RAM with sized, extended accesses.
// Define MISALIGN_SPLIT_EN to split misaligned accesses into two RAM cycles instead of rejecting them.
module mem_port_ctrl (
    input  logic        clk,
    input  logic        reset_b,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_rnw,
    input  logic [14:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [12:0] ram_address,
    output logic [31:0] ram_din,
    output logic        ram_rnw,
    output logic [3:0]  ram_cs_b,
    input  logic [31:0] ram_dout
);
    typedef enum logic [2:0] {IDLE, ISSUE, ISSUE2, WAIT, RESP} state_t;
    state_t state, next_state;
    logic        rnw_q, sgn_q, rnw, sgn, err, split, drive1, drive2;
    logic [14:0] addr_q, addr;
    logic [1:0]  size_q, size, off;
    logic [31:0] wdata_q, wdata, lo_q, hi_q, lo_v, hi_v, shifted, rdata_ext;
    logic [7:0]  lanes;
    logic [63:0] wide;
    // In IDLE the live request is decoded so the first RAM cycle can be registered at the accept edge.
    always_comb begin
        rnw = state == IDLE ? req_rnw : rnw_q;
        sgn = state == IDLE ? req_signed : sgn_q;
        addr = state == IDLE ? req_addr : addr_q;
        size = state == IDLE ? req_size : size_q;
        wdata = state == IDLE ? req_wdata : wdata_q;
        off = addr[1:0];
        lanes = {4'h0, size == 2'b00 ? 4'h1 : size == 2'b01 ? 4'h3 : 4'hF} << off;
        wide = {32'h0, wdata & (size == 2'b00 ? 32'h0000_00FF : size == 2'b01 ? 32'h0000_FFFF : 32'hFFFF_FFFF)} << {off, 3'b000};
`ifdef MISALIGN_SPLIT_EN
        err = size == 2'b11;
        split = size != 2'b11 && lanes[7:4] != 4'h0;
`else
        err = size == 2'b11 || (size == 2'b01 && off[0]) || (size == 2'b10 && off != 2'b00);
        split = 1'b0;
`endif
        lo_v = state == WAIT && !split ? ram_dout : lo_q;
        hi_v = state == WAIT && split ? ram_dout : hi_q;
        shifted = 32'({hi_v, lo_v} >> {off, 3'b000});
        rdata_ext = size == 2'b00 ? {{24{sgn & shifted[7]}}, shifted[7:0]} :
                    size == 2'b01 ? {{16{sgn & shifted[15]}}, shifted[15:0]} : shifted;
    end
    always_ff @(posedge clk) begin
        if (!reset_b) state <= IDLE;
        else state <= next_state;
    end
    always_comb begin
        next_state = state == IDLE ? (req_valid ? ISSUE : IDLE) :
                     state == ISSUE ? (err ? RESP : split ? ISSUE2 : rnw ? WAIT : RESP) :
                     state == ISSUE2 ? (rnw ? WAIT : RESP) :
                     state == WAIT ? RESP : IDLE;
    end
    always_comb begin
        req_ready = state == IDLE && reset_b;
        drive1 = next_state == ISSUE && !err;
        drive2 = next_state == ISSUE2;
    end
    always_ff @(posedge clk) begin
        if (state == IDLE) begin
            rnw_q <= req_rnw;
            sgn_q <= req_signed;
            addr_q <= req_addr;
            size_q <= req_size;
            wdata_q <= req_wdata;
        end
        if (state == ISSUE2) lo_q <= ram_dout;
        if (state == WAIT && split) hi_q <= ram_dout;
        if (state == WAIT && !split) lo_q <= ram_dout;
    end
    always_ff @(posedge clk) begin
        if (!reset_b) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'h0;
            rsp_err <= 1'b0;
            ram_cs_b <= 4'hF;
            ram_rnw <= 1'b1;
            ram_address <= 13'h0;
            ram_din <= 32'h0;
        end else begin
            rsp_valid <= next_state == RESP;
            if (next_state == RESP) begin
                rsp_err <= err;
                rsp_rdata <= err || !rnw ? 32'h0 : rdata_ext;
            end
            ram_cs_b <= drive1 ? ~lanes[3:0] : drive2 ? ~lanes[7:4] : 4'hF;
            ram_rnw <= drive1 || drive2 ? rnw : 1'b1;
            if (drive1) begin
                ram_address <= addr[14:2];
                ram_din <= wide[31:0];
            end
            if (drive2) begin
                ram_address <= addr[14:2] + 13'd1;
                ram_din <= wide[63:32];
            end
        end
    end
endmodule
